// File: rtl/stopwatch_counter.sv
// Stopwatch timing stage: BCD SS.hh counter with start/stop/clear control and a
// multiplexed digit scan. Define LAP_EN to enable the lap (display freeze) state.
module stopwatch_counter #(
  parameter int TICK_DIV = 100000,
  parameter int SCAN_DIV = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic       running,
  output logic       ovf,
  output logic [3:0] d3,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic [3:0] bcd,
  output logic [3:0] an,
  output logic       dp
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

`ifdef LAP_EN
  localparam logic LAP_ON = 1'b1;
`else
  localparam logic LAP_ON = 1'b0;
`endif

  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_LAP} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   presc_p0;
  logic [15:0]     cnt_p0;
  logic [15:0]     disp_p1;
  logic [SW-1:0]   scan_p0;
  logic [1:0]      sel_p0, sel_nxt;
  logic [16:0]     inc;
  logic            lap_go;
  logic            tick;

  // Ripple BCD increment over SS.hh; bit 16 flags the 59.99 -> 00.00 wrap.
  function automatic logic [16:0] bcd_inc(input logic [15:0] c);
    logic [15:0] r;
    logic        cy;
    r  = c;
    cy = 1'b0;
    if (c[3:0] != 4'd9) r[3:0] = c[3:0] + 4'd1;
    else begin
      r[3:0] = 4'd0;
      if (c[7:4] != 4'd9) r[7:4] = c[7:4] + 4'd1;
      else begin
        r[7:4] = 4'd0;
        if (c[11:8] != 4'd9) r[11:8] = c[11:8] + 4'd1;
        else begin
          r[11:8] = 4'd0;
          if (c[15:12] != 4'd5) r[15:12] = c[15:12] + 4'd1;
          else begin
            r[15:12] = 4'd0;
            cy       = 1'b1;
          end
        end
      end
    end
    return {cy, r};
  endfunction

  function automatic logic [3:0] digit_mux(input logic [15:0] d, input logic [1:0] s);
    return d[4*s +: 4];
  endfunction

  assign lap_go  = lap & LAP_ON;
  assign running = (state != ST_STOP);
  assign tick    = running && (presc_p0 == PRE_MAX);
  assign inc     = bcd_inc(cnt_p0);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_STOP: if (start_stop && !clear) state_nxt = ST_RUN;
      ST_RUN: begin
        if (start_stop)  state_nxt = ST_STOP;
        else if (lap_go) state_nxt = ST_LAP;
      end
      ST_LAP: begin
        if (start_stop)  state_nxt = ST_STOP;
        else if (lap_go) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_STOP;
    endcase
  end

  // Stage p0: control FSM, prescaler and count
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_STOP;
      presc_p0 <= '0;
      cnt_p0   <= '0;
      ovf      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_STOP && clear) begin
        presc_p0 <= '0;
        cnt_p0   <= '0;
        ovf      <= 1'b0;
      end else if (running) begin
        presc_p0 <= tick ? '0 : presc_p0 + PW'(1);
        if (tick) begin
          cnt_p0 <= inc[15:0];
          if (inc[16]) ovf <= 1'b1;
        end
      end
    end
  end

  // Stage p1: display register, frozen while in lap
  always_ff @(posedge clk) begin
    if (rst)                  disp_p1 <= '0;
    else if (state != ST_LAP) disp_p1 <= cnt_p0;
  end

  assign {d3, d2, d1, d0} = disp_p1;

  assign sel_nxt = (scan_p0 == SCAN_MAX) ? sel_p0 + 2'd1 : sel_p0;

  // Stage p2: digit scan; outputs follow the next select so an and bcd move together
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_p0 <= '0;
      sel_p0  <= 2'd0;
      an      <= 4'b0001;
      bcd     <= 4'd0;
      dp      <= 1'b0;
    end else begin
      scan_p0 <= (scan_p0 == SCAN_MAX) ? '0 : scan_p0 + SW'(1);
      sel_p0  <= sel_nxt;
      an      <= 4'b0001 << sel_nxt;
      bcd     <= digit_mux(disp_p1, sel_nxt);
      dp      <= (sel_nxt == 2'd2);
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: two instances (TICK_DIV=4 and TICK_DIV=2)
// share stimulus; each scenario task checks the instance it targets.
module tb_stopwatch_counter;

  logic clk = 1'b0;
  logic rst = 1'b0, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;

  logic       running_a, ovf_a, dp_a;
  logic [3:0] d3_a, d2_a, d1_a, d0_a, bcd_a, an_a;
  logic       running_b, ovf_b, dp_b;
  logic [3:0] d3_b, d2_b, d1_b, d0_b, bcd_b, an_b;

  logic [15:0] da, db;
  assign da = {d3_a, d2_a, d1_a, d0_a};
  assign db = {d3_b, d2_b, d1_b, d0_b};

  int n_pass = 0;
  int n_total = 0;

`ifdef LAP_EN
  localparam logic [15:0] LAP_HELD = 16'h0005;
`else
  localparam logic [15:0] LAP_HELD = 16'h0008;
`endif

  stopwatch_counter #(.TICK_DIV(4), .SCAN_DIV(2)) u_a (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap),
    .running(running_a), .ovf(ovf_a), .d3(d3_a), .d2(d2_a), .d1(d1_a), .d0(d0_a),
    .bcd(bcd_a), .an(an_a), .dp(dp_a)
  );

  stopwatch_counter #(.TICK_DIV(2), .SCAN_DIV(2)) u_b (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap),
    .running(running_b), .ovf(ovf_b), .d3(d3_b), .d2(d2_b), .d1(d1_b), .d0(d0_b),
    .bcd(bcd_b), .an(an_b), .dp(dp_b)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    tick(1);
    start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_an;
    do_reset();
    n_total++; if (running_a !== 1'b0) $display("FAIL rst_running: got %b want 0", running_a); else n_pass++;
    n_total++; if (da !== 16'h0000) $display("FAIL rst_digits: got %h want 0000", da); else n_pass++;
    n_total++; if (an_a !== 4'b0001) $display("FAIL rst_an: got %b want 0001", an_a); else n_pass++;
    n_total++; if (bcd_a !== 4'd0 || dp_a !== 1'b0 || ovf_a !== 1'b0)
      $display("FAIL rst_misc: got bcd=%h dp=%b ovf=%b want 0 0 0", bcd_a, dp_a, ovf_a); else n_pass++;
    exp_an = 4'b0001;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      n_total++; if (an_a !== exp_an) $display("FAIL scan_hold%0d: got %b want %b", i, an_a, exp_an); else n_pass++;
      tick(1);
      exp_an = 4'b0001 << (i % 4);
      n_total++; if (an_a !== exp_an) $display("FAIL scan_step%0d: got %b want %b", i, an_a, exp_an); else n_pass++;
      n_total++; if (dp_a !== (i % 4 == 2)) $display("FAIL scan_dp%0d: got %b want %b", i, dp_a, (i % 4 == 2)); else n_pass++;
    end
  endtask

  task automatic test_counting();
    logic [3:0] seen, exp_b;
    do_reset();
    pulse_ss();
    tick(40);
    n_total++; if (da !== 16'h0009) $display("FAIL count_lag: got %h want 0009", da); else n_pass++;
    tick(1);
    n_total++; if (da !== 16'h0010) $display("FAIL count_40: got %h want 0010", da); else n_pass++;
    n_total++; if (running_a !== 1'b1) $display("FAIL count_running: got %b want 1", running_a); else n_pass++;
    pulse_ss();
    n_total++; if (running_a !== 1'b0) $display("FAIL count_stop: got %b want 0", running_a); else n_pass++;
    tick(10);
    n_total++; if (da !== 16'h0010) $display("FAIL count_frozen: got %h want 0010", da); else n_pass++;
    seen = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick(2);
      seen |= an_a;
      exp_b = (an_a == 4'b0010) ? 4'd1 : 4'd0;
      n_total++; if (bcd_a !== exp_b) $display("FAIL scan_bcd an=%b: got %h want %h", an_a, bcd_a, exp_b); else n_pass++;
    end
    n_total++; if (seen !== 4'b1111) $display("FAIL scan_cover: got %b want 1111", seen); else n_pass++;
  endtask

  task automatic test_pause();
    do_reset();
    pulse_ss();
    tick(5);
    pulse_ss();
    tick(20);
    n_total++; if (da !== 16'h0001) $display("FAIL pause_held: got %h want 0001", da); else n_pass++;
    pulse_ss();
    tick(2);
    n_total++; if (da !== 16'h0001) $display("FAIL pause_early: got %h want 0001", da); else n_pass++;
    tick(1);
    n_total++; if (da !== 16'h0002) $display("FAIL pause_resume: got %h want 0002", da); else n_pass++;
    pulse_ss();
  endtask

  task automatic test_simultaneous();
    tick(2);
    clear = 1'b1;
    start_stop = 1'b1;
    tick(1);
    clear = 1'b0;
    start_stop = 1'b0;
    n_total++; if (running_a !== 1'b0) $display("FAIL simul_state: got %b want 0", running_a); else n_pass++;
    tick(1);
    n_total++; if (da !== 16'h0000) $display("FAIL simul_clear: got %h want 0000", da); else n_pass++;
    tick(8);
    n_total++; if (da !== 16'h0000 || running_a !== 1'b0)
      $display("FAIL simul_idle: got %h/%b want 0000/0", da, running_a); else n_pass++;
    pulse_ss();
    tick(8);
    pulse_clear();
    tick(4);
    n_total++; if (da !== 16'h0003) $display("FAIL run_clear_ignored: got %h want 0003", da); else n_pass++;
    n_total++; if (running_a !== 1'b1) $display("FAIL run_clear_running: got %b want 1", running_a); else n_pass++;
    pulse_ss();
  endtask

  task automatic test_wrap();
    do_reset();
    pulse_ss();
    tick(11999);
    n_total++; if (db !== 16'h5999) $display("FAIL wrap_top: got %h want 5999", db); else n_pass++;
    n_total++; if (ovf_b !== 1'b0) $display("FAIL wrap_ovf_early: got %b want 0", ovf_b); else n_pass++;
    tick(1);
    n_total++; if (ovf_b !== 1'b1) $display("FAIL wrap_ovf: got %b want 1", ovf_b); else n_pass++;
    tick(1);
    n_total++; if (db !== 16'h0000) $display("FAIL wrap_zero: got %h want 0000", db); else n_pass++;
    pulse_ss();
    tick(1);
    n_total++; if (db !== 16'h0001 || ovf_b !== 1'b1 || running_b !== 1'b0)
      $display("FAIL wrap_stop: got %h/%b/%b want 0001/1/0", db, ovf_b, running_b); else n_pass++;
    pulse_clear();
    n_total++; if (ovf_b !== 1'b0) $display("FAIL wrap_clear_ovf: got %b want 0", ovf_b); else n_pass++;
    tick(1);
    n_total++; if (db !== 16'h0000) $display("FAIL wrap_clear_d: got %h want 0000", db); else n_pass++;
  endtask

  task automatic test_lap();
    do_reset();
    pulse_ss();
    tick(20);
    lap = 1'b1;
    tick(1);
    lap = 1'b0;
    n_total++; if (running_a !== 1'b1) $display("FAIL lap_running: got %b want 1", running_a); else n_pass++;
    tick(12);
    n_total++; if (da !== LAP_HELD) $display("FAIL lap_freeze: got %h want %h", da, LAP_HELD); else n_pass++;
    lap = 1'b1;
    tick(1);
    lap = 1'b0;
    n_total++; if (da !== LAP_HELD) $display("FAIL lap_release_edge: got %h want %h", da, LAP_HELD); else n_pass++;
    tick(1);
    n_total++; if (da !== 16'h0008) $display("FAIL lap_release: got %h want 0008", da); else n_pass++;
    pulse_ss();
  endtask

  task automatic test_reset_midrun();
    do_reset();
    pulse_ss();
    tick(10);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_total++; if (running_a !== 1'b0 || da !== 16'h0000)
      $display("FAIL midrst_state: got %b/%h want 0/0000", running_a, da); else n_pass++;
    n_total++; if (an_a !== 4'b0001 || bcd_a !== 4'd0)
      $display("FAIL midrst_scan: got %b/%h want 0001/0", an_a, bcd_a); else n_pass++;
    tick(6);
    n_total++; if (da !== 16'h0000) $display("FAIL midrst_idle: got %h want 0000", da); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_counting();
    test_pause();
    test_simultaneous();
    test_wrap();
    test_lap();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
